// File: rtl/lpif_pack_pkg.sv
// Shared types for the LPIF single-beat to upstream-pair packer.
// Beat layout, pack state encoding and the default flush timeout.
package lpif_pack_pkg;

  typedef struct packed {
    logic [3:0]  state;
    logic [1:0]  protid;
    logic [31:0] data;
    logic        dvalid;
    logic        crc;
    logic        crc_valid;
    logic        valid;
  } beat_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_t;

  localparam int unsigned FLUSH_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/lpif_txrx_x1_asym1_half_ustrm_pack_flush_ctr.sv
// Idle-timeout counter and saturating flush counter for the packer.
// Built only when LPIF_USTRM_PACK_FLUSH_EN is defined.
module lpif_ustrm_pack_flush_ctr
  import lpif_pack_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic        clk_wr,
  input  logic        rst_wr_n,
  input  logic        half,
  input  logic        accept,
  input  logic        flush,
  output logic        flush_due,
  output logic [15:0] flush_cnt
);

  localparam logic [7:0] DUE_AT = 8'(FLUSH_CYCLES - 1);

  logic [7:0] idle_cnt;

  // Flush fires on the edge where this idle cycle would bring the count to FLUSH_CYCLES.
  assign flush_due = (idle_cnt >= DUE_AT);

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      idle_cnt <= '0;
    end else if (accept || !half || flush) begin
      idle_cnt <= '0;
    end else if (idle_cnt != 8'hFF) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      flush_cnt <= '0;
    end else if (flush && flush_cnt != 16'hFFFF) begin
      flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/lpif_txrx_x1_asym1_half_ustrm_pack.sv
// Packs pairs of single-beat LPIF transfers into one two-lane upstream word.
// Optional idle flush of a lone lane-0 beat: define LPIF_USTRM_PACK_FLUSH_EN.
module lpif_txrx_x1_asym1_half_ustrm_pack
  import lpif_pack_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic        clk_wr,
  input  logic        rst_wr_n,
  input  logic [3:0]  in_state,
  input  logic [1:0]  in_protid,
  input  logic [31:0] in_data,
  input  logic        in_dvalid,
  input  logic        in_crc,
  input  logic        in_crc_valid,
  input  logic        in_valid,
  input  logic        in_push,
  output logic        in_ready,
  output logic [7:0]  ustrm_state,
  output logic [3:0]  ustrm_protid,
  output logic [63:0] ustrm_data,
  output logic [1:0]  ustrm_dvalid,
  output logic [1:0]  ustrm_crc,
  output logic [1:0]  ustrm_crc_valid,
  output logic [1:0]  ustrm_valid,
  output logic        ustrm_push,
  input  logic        ustrm_ready,
  output logic [15:0] flush_cnt
);

  pack_state_t state_q, state_d;
  beat_t       in_beat, lane0_q, out_lo, out_hi;
  logic        out_vld, accept, pair_load, flush_load;

  assign in_beat = '{state: in_state, protid: in_protid, data: in_data,
                     dvalid: in_dvalid, crc: in_crc, crc_valid: in_crc_valid,
                     valid: in_valid};

  assign in_ready = ~out_vld | ustrm_ready;
  assign accept   = in_push & in_ready;

`ifdef LPIF_USTRM_PACK_FLUSH_EN
  logic flush_due;

  lpif_ustrm_pack_flush_ctr #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_flush_ctr (
    .clk_wr    (clk_wr),
    .rst_wr_n  (rst_wr_n),
    .half      (state_q == HALF),
    .accept    (accept),
    .flush     (flush_load),
    .flush_due (flush_due),
    .flush_cnt (flush_cnt)
  );

  // An accepted beat always takes priority over the timeout.
  assign flush_load = (state_q == HALF) & ~accept & in_ready & flush_due;
`else
  assign flush_load = 1'b0;
  assign flush_cnt  = '0;
`endif

  always_comb begin
    state_d   = state_q;
    pair_load = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) state_d = HALF;
      end
      HALF: begin
        if (accept) begin
          state_d   = EMPTY;
          pair_load = 1'b1;
        end else if (flush_load) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) state_q <= EMPTY;
    else           state_q <= state_d;
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      lane0_q <= '0;
    end else if (accept && state_q == EMPTY) begin
      lane0_q <= in_beat;
    end
  end

  // A new load on the draining edge keeps out_vld high for zero-bubble streaming.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      out_lo  <= '0;
      out_hi  <= '0;
      out_vld <= 1'b0;
    end else if (pair_load) begin
      out_lo  <= lane0_q;
      out_hi  <= in_beat;
      out_vld <= 1'b1;
    end else if (flush_load) begin
      out_lo  <= lane0_q;
      out_hi  <= '0;
      out_vld <= 1'b1;
    end else if (ustrm_ready) begin
      out_vld <= 1'b0;
    end
  end

  assign ustrm_push      = out_vld;
  assign ustrm_state     = {out_hi.state,     out_lo.state};
  assign ustrm_protid    = {out_hi.protid,    out_lo.protid};
  assign ustrm_data      = {out_hi.data,      out_lo.data};
  assign ustrm_dvalid    = {out_hi.dvalid,    out_lo.dvalid};
  assign ustrm_crc       = {out_hi.crc,       out_lo.crc};
  assign ustrm_crc_valid = {out_hi.crc_valid, out_lo.crc_valid};
  assign ustrm_valid     = {out_hi.valid,     out_lo.valid};

endmodule

// File: tb/tb_lpif_txrx_x1_asym1_half_ustrm_pack.sv
// Self-checking bench for the LPIF upstream pair packer against a beat-level model.
// Flush scenarios are exercised when LPIF_USTRM_PACK_FLUSH_EN is defined.
module tb_lpif_txrx_x1_asym1_half_ustrm_pack;
  import lpif_pack_pkg::*;

  localparam int unsigned FC = 4;

  logic        clk_wr, rst_wr_n;
  logic [3:0]  in_state;
  logic [1:0]  in_protid;
  logic [31:0] in_data;
  logic        in_dvalid, in_crc, in_crc_valid, in_valid, in_push, in_ready;
  logic [7:0]  ustrm_state;
  logic [3:0]  ustrm_protid;
  logic [63:0] ustrm_data;
  logic [1:0]  ustrm_dvalid, ustrm_crc, ustrm_crc_valid, ustrm_valid;
  logic        ustrm_push, ustrm_ready;
  logic [15:0] flush_cnt;

  lpif_txrx_x1_asym1_half_ustrm_pack #(.FLUSH_CYCLES(FC)) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
    .in_state(in_state), .in_protid(in_protid), .in_data(in_data),
    .in_dvalid(in_dvalid), .in_crc(in_crc), .in_crc_valid(in_crc_valid),
    .in_valid(in_valid), .in_push(in_push), .in_ready(in_ready),
    .ustrm_state(ustrm_state), .ustrm_protid(ustrm_protid), .ustrm_data(ustrm_data),
    .ustrm_dvalid(ustrm_dvalid), .ustrm_crc(ustrm_crc), .ustrm_crc_valid(ustrm_crc_valid),
    .ustrm_valid(ustrm_valid), .ustrm_push(ustrm_push), .ustrm_ready(ustrm_ready),
    .flush_cnt(flush_cnt)
  );

  initial clk_wr = 1'b0;
  always #5 clk_wr = ~clk_wr;

  int errors = 0;
  int checks = 0;

  // Reference model: beats waiting for a partner, and the word last offered downstream.
  beat_t       held_q[$];
  beat_t       m_lo, m_hi;
  logic        m_vld;
  int          m_idle;
  logic [15:0] m_fc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic beat_t randBeat();
    beat_t b;
    b.state     = 4'($urandom);
    b.protid    = 2'($urandom);
    b.data      = $urandom;
    b.dvalid    = 1'($urandom);
    b.crc       = 1'($urandom);
    b.crc_valid = 1'($urandom);
    b.valid     = 1'($urandom);
    return b;
  endfunction

  function automatic beat_t mkBeat(input logic [3:0] st, input logic [31:0] d);
    beat_t b;
    b = '0;
    b.state = st;
    b.data  = d;
    b.valid = 1'b1;
    return b;
  endfunction

  task automatic modelReset();
    held_q.delete();
    m_lo = '0; m_hi = '0; m_vld = 1'b0; m_idle = 0; m_fc = '0;
  endtask

  task automatic modelEdge(input logic acc, input beat_t b, input logic rdy);
    logic drained;
    drained = m_vld & rdy;
    if (acc && held_q.size() == 1) begin
      m_lo = held_q.pop_front(); m_hi = b; m_vld = 1'b1; m_idle = 0;
    end else if (acc) begin
      held_q.push_back(b); m_idle = 0;
      if (drained) m_vld = 1'b0;
`ifdef LPIF_USTRM_PACK_FLUSH_EN
    end else if (held_q.size() == 1 && (m_idle + 1) >= int'(FC) && (!m_vld || rdy)) begin
      m_lo = held_q.pop_front(); m_hi = '0; m_vld = 1'b1; m_idle = 0;
      if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
`endif
    end else begin
      if (drained) m_vld = 1'b0;
      if (held_q.size() == 1 && m_idle < 255) m_idle++;
    end
  endtask

  task automatic checkOutput();
    chk("ustrm_push",   64'(ustrm_push),   64'(m_vld));
    chk("ustrm_state",  64'(ustrm_state),  64'({m_hi.state, m_lo.state}));
    chk("ustrm_protid", 64'(ustrm_protid), 64'({m_hi.protid, m_lo.protid}));
    chk("ustrm_data",   ustrm_data,        {m_hi.data, m_lo.data});
    chk("ustrm_quals",
        64'({ustrm_dvalid, ustrm_crc, ustrm_crc_valid, ustrm_valid}),
        64'({m_hi.dvalid, m_lo.dvalid, m_hi.crc, m_lo.crc,
             m_hi.crc_valid, m_lo.crc_valid, m_hi.valid, m_lo.valid}));
    chk("flush_cnt",    64'(flush_cnt),    64'(m_fc));
  endtask

  // One clock of stimulus: drive, check in_ready before the edge, advance model, check after.
  task automatic applyStimulus(input logic push, input beat_t b, input logic rdy);
    logic exp_ready;
    in_push = push; ustrm_ready = rdy;
    in_state = b.state; in_protid = b.protid; in_data = b.data;
    in_dvalid = b.dvalid; in_crc = b.crc; in_crc_valid = b.crc_valid; in_valid = b.valid;
    #1;
    exp_ready = ~m_vld | rdy;
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    @(posedge clk_wr);
    modelEdge(push & exp_ready, b, rdy);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    #1;
    rst_wr_n = 1'b0;
    modelReset();
    #1;
    checkOutput();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk_wr);
    rst_wr_n = 1'b1;
  endtask

  initial begin
    int pulses;
    beat_t idle;
    idle = '0;
    rst_wr_n = 1'b0;
    in_push = 1'b0; ustrm_ready = 1'b0;
    in_state = '0; in_protid = '0; in_data = '0;
    in_dvalid = 1'b0; in_crc = 1'b0; in_crc_valid = 1'b0; in_valid = 1'b0;
    modelReset();
    #3;
    checkOutput();
    @(negedge clk_wr);
    rst_wr_n = 1'b1;

    // Basic pairing and lane placement
    applyStimulus(1'b1, mkBeat(4'h1, 32'h11111111), 1'b1);
    chk("first_beat_no_push", 64'(ustrm_push), 64'd0);
    applyStimulus(1'b1, mkBeat(4'h2, 32'h22222222), 1'b1);
    chk("pair_push", 64'(ustrm_push), 64'd1);
    chk("pair_data", ustrm_data, 64'h22222222_11111111);
    applyStimulus(1'b0, idle, 1'b1);

    // Eight back-to-back beats
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, randBeat(), 1'b1);
      if (ustrm_push) pulses++;
    end
    chk("pulse_count", 64'(pulses), 64'd4);
    applyStimulus(1'b0, idle, 1'b1);

    // Backpressure while a pair is held
    applyStimulus(1'b1, randBeat(), 1'b1);
    applyStimulus(1'b1, randBeat(), 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, randBeat(), 1'b0);
    chk("stalled_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, randBeat(), 1'b1);
    applyStimulus(1'b1, randBeat(), 1'b1);

    // Random traffic
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 3) != 0), randBeat(), 1'($urandom_range(0, 2) != 0));

    // Lone lane-0 beat followed by idle
    doReset();
    applyStimulus(1'b1, mkBeat(4'h3, 32'hCAFE0003), 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, idle, 1'b1);
    chk("lone_idle3_push", 64'(ustrm_push), 64'd0);
    applyStimulus(1'b0, idle, 1'b1);
`ifdef LPIF_USTRM_PACK_FLUSH_EN
    chk("flush_push",     64'(ustrm_push),       64'd1);
    chk("flush_valid",    64'(ustrm_valid),      64'd1);
    chk("flush_hi_data",  64'(ustrm_data[63:32]), 64'd0);
    chk("flush_lo_state", 64'(ustrm_state[3:0]), 64'h3);
    chk("flush_count",    64'(flush_cnt),        64'd1);
`else
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, idle, 1'b1);
    chk("noflush_push",  64'(ustrm_push), 64'd0);
    chk("noflush_count", 64'(flush_cnt),  64'd0);
`endif

    // Partner beat arriving on the fourth idle cycle
    doReset();
    applyStimulus(1'b1, mkBeat(4'h4, 32'h00000044), 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, idle, 1'b1);
    applyStimulus(1'b1, mkBeat(4'h5, 32'h00000055), 1'b1);
    chk("late_pair_data",  ustrm_data,       64'h00000055_00000044);
    chk("late_pair_count", 64'(flush_cnt),   64'd0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, idle, 1'b1);

    // Reset while HALF discards the held beat
    applyStimulus(1'b1, mkBeat(4'h6, 32'hDEAD0006), 1'b1);
    doReset();
    chk("rst_push", 64'(ustrm_push), 64'd0);
    chk("rst_data", ustrm_data, 64'd0);
    applyStimulus(1'b1, mkBeat(4'h7, 32'hAAAA0001), 1'b1);
    applyStimulus(1'b1, mkBeat(4'h8, 32'hBBBB0002), 1'b1);
    chk("post_rst_data",  ustrm_data,        64'hBBBB0002_AAAA0001);
    chk("post_rst_state", 64'(ustrm_state),  64'h87);
    applyStimulus(1'b0, idle, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
